// File: rtl/sram_port_arbiter.sv
// Arbitrates the I-fetch and D ports onto one single-port SRAM macro.
// One transaction in flight; D has priority with a starvation guard for I.
module sram_port_arbiter #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned RD_LATENCY = 1,
    parameter int unsigned MAX_STARVE = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  i_req_valid_i,
    output logic                  i_req_ready_o,
    input  logic [31:0]           i_req_addr_i,
    output logic                  i_rsp_valid_o,
    output logic [31:0]           i_rsp_rdata_o,
    output logic                  i_rsp_err_o,
    input  logic                  d_req_valid_i,
    output logic                  d_req_ready_o,
    input  logic [31:0]           d_req_addr_i,
    input  logic                  d_req_we_i,
    input  logic [31:0]           d_req_wdata_i,
    input  logic [3:0]            d_req_wmask_i,
    output logic                  d_rsp_valid_o,
    output logic [31:0]           d_rsp_rdata_o,
    output logic                  d_rsp_err_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [3:0]            sram_wmask_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [31:0]           sram_din_o,
    input  logic [31:0]           sram_dout_i,
    output logic                  busy_o
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_e;

    localparam logic [2:0] LAT        = 3'(RD_LATENCY);
    localparam logic [3:0] STARVE_LIM = 4'(MAX_STARVE);

    state_e                  state_q;
    logic [2:0]              cnt_q;
    logic [3:0]              starve_q;
    logic                    gnt_i_q;
    logic                    we_q;
    logic                    csb_q;
    logic                    web_q;
    logic [3:0]              wmask_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [31:0]             din_q;
    logic                    i_rsp_valid_q;
    logic                    d_rsp_valid_q;
    logic [31:0]             i_rdata_q;
    logic [31:0]             d_rdata_q;
    logic                    i_err_q;
    logic                    d_err_q;

    logic                    idle;
    logic                    starved;
    logic                    i_win;
    logic                    i_fire;
    logic                    d_fire;
    logic [31:0]             req_addr;
    logic                    req_we;
    logic                    req_oor;
    logic [ADDR_WIDTH-1:0]   req_word;
    logic                    unused_addr_lsb;

    assign idle    = (state_q == IDLE);
    assign starved = (starve_q == STARVE_LIM);

    // D is the default winner; I wins when D is absent or I has starved
    assign i_win = i_req_valid_i & (~d_req_valid_i | starved);

    assign i_req_ready_o = idle & i_win;
    assign d_req_ready_o = idle & ~i_win;

    assign i_fire = i_req_ready_o & i_req_valid_i;
    assign d_fire = d_req_ready_o & d_req_valid_i;

    assign req_addr = i_win ? i_req_addr_i : d_req_addr_i;
    assign req_we   = ~i_win & d_req_we_i;
    assign req_oor  = |req_addr[31:ADDR_WIDTH+2];
    assign req_word = req_addr[ADDR_WIDTH+1:2];

    assign unused_addr_lsb = ^{i_req_addr_i[1:0], d_req_addr_i[1:0]};

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            starve_q      <= '0;
            gnt_i_q       <= 1'b0;
            we_q          <= 1'b0;
            csb_q         <= 1'b1;
            web_q         <= 1'b1;
            wmask_q       <= '0;
            addr_q        <= '0;
            din_q         <= '0;
            i_rsp_valid_q <= 1'b0;
            d_rsp_valid_q <= 1'b0;
            i_rdata_q     <= '0;
            d_rdata_q     <= '0;
            i_err_q       <= 1'b0;
            d_err_q       <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (i_fire | d_fire) begin
                        gnt_i_q <= i_fire;
                        we_q    <= req_we;
                        if (i_fire) begin
                            starve_q <= '0;
                        end else if (i_req_valid_i && !starved) begin
                            starve_q <= starve_q + 4'd1;
                        end
                        if (req_oor) begin
                            state_q       <= RESP;
                            i_rsp_valid_q <= i_fire;
                            d_rsp_valid_q <= d_fire;
                            i_err_q       <= i_fire;
                            d_err_q       <= d_fire;
                        end else begin
                            state_q <= ISSUE;
                            csb_q   <= 1'b0;
                            web_q   <= ~req_we;
                            wmask_q <= req_we ? d_req_wmask_i : 4'b0;
                            addr_q  <= req_word;
                            din_q   <= req_we ? d_req_wdata_i : 32'b0;
                        end
                    end
                end
                ISSUE: begin
                    csb_q   <= 1'b1;
                    web_q   <= 1'b1;
                    wmask_q <= '0;
                    addr_q  <= '0;
                    din_q   <= '0;
                    if (we_q) begin
                        state_q       <= RESP;
                        d_rsp_valid_q <= 1'b1;
                        d_rdata_q     <= '0;
                    end else begin
                        state_q <= WAIT;
                        cnt_q   <= LAT;
                    end
                end
                WAIT: begin
                    if (cnt_q == 3'd1) begin
                        state_q <= RESP;
                        if (gnt_i_q) begin
                            i_rsp_valid_q <= 1'b1;
                            i_rdata_q     <= sram_dout_i;
                        end else begin
                            d_rsp_valid_q <= 1'b1;
                            d_rdata_q     <= sram_dout_i;
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                RESP: begin
                    state_q       <= IDLE;
                    i_rsp_valid_q <= 1'b0;
                    d_rsp_valid_q <= 1'b0;
                    i_rdata_q     <= '0;
                    d_rdata_q     <= '0;
                    i_err_q       <= 1'b0;
                    d_err_q       <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_rsp_valid_o = i_rsp_valid_q;
    assign i_rsp_rdata_o = i_rdata_q;
    assign i_rsp_err_o   = i_err_q;
    assign d_rsp_valid_o = d_rsp_valid_q;
    assign d_rsp_rdata_o = d_rdata_q;
    assign d_rsp_err_o   = d_err_q;
    assign sram_csb_o    = csb_q;
    assign sram_web_o    = web_q;
    assign sram_wmask_o  = wmask_q;
    assign sram_addr_o   = addr_q;
    assign sram_din_o    = din_q;
    assign busy_o        = ~idle;

endmodule
